// File: rtl/fwd_hazard_unit_pkg.sv
// fwd_hazard_unit_pkg: forward-select codes and pipe-tag layout shared by the hazard unit.
package fwd_hazard_unit_pkg;
  localparam int REG_AW_DEF = 5;
  localparam logic [1:0] FWD_QA  = 2'b00;
  localparam logic [1:0] FWD_R   = 2'b01;
  localparam logic [1:0] FWD_MR  = 2'b10;
  localparam logic [1:0] FWD_MDO = 2'b11;
  typedef struct packed {
    logic                  wreg;
    logic                  m2reg;
    logic [REG_AW_DEF-1:0] rn;
  } tag_t;
  localparam tag_t BUBBLE = '0;
endpackage

// File: rtl/fwd_hazard_unit_sel.sv
// fwd_sel: per-operand EXE/MEM tag match and youngest-wins forward select encoder.
module fwd_sel import fwd_hazard_unit_pkg::*; #(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              act_i,
  input  logic [REG_AW-1:0] src_i,
  input  logic              ewreg_i,
  input  logic              em2reg_i,
  input  logic [REG_AW-1:0] ern_i,
  input  logic              mwreg_i,
  input  logic              mm2reg_i,
  input  logic [REG_AW-1:0] mrn_i,
  output logic [1:0]        sel_o,
  output logic              load_hit_o
);
  logic e_hit, m_hit;
  always_comb begin
    e_hit      = act_i & ewreg_i & (ern_i == src_i) & (|ern_i);
    m_hit      = act_i & mwreg_i & (mrn_i == src_i) & (|mrn_i);
    load_hit_o = e_hit & em2reg_i;
    // an EXE load hit masks any older MEM match: the operand waits a cycle instead
    sel_o      = e_hit ? (em2reg_i ? FWD_QA : FWD_R) :
                 m_hit ? (mm2reg_i ? FWD_MDO : FWD_MR) : FWD_QA;
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: tracks EXE/MEM destination tags, drives operand forward selects,
// inserts a one-cycle load-use bubble and counts stalled cycles.
module fwd_hazard_unit import fwd_hazard_unit_pkg::*; #(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic              d_use_rs,
  input  logic              d_use_rt,
  input  logic              d_wreg,
  input  logic              d_m2reg,
  input  logic [REG_AW-1:0] d_rn,
  input  logic              clr_cnt,
  output logic [1:0]        fwda,
  output logic [1:0]        fwdb,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);
  // tag layout {wreg, m2reg, rn}
  logic [REG_AW+1:0] e_q, e_d, m_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lh_a, lh_b;
  fwd_sel #(.REG_AW(REG_AW)) u_sel_a (
    .act_i(d_valid & d_use_rs), .src_i(d_rs),
    .ewreg_i(e_q[REG_AW+1]), .em2reg_i(e_q[REG_AW]), .ern_i(e_q[REG_AW-1:0]),
    .mwreg_i(m_q[REG_AW+1]), .mm2reg_i(m_q[REG_AW]), .mrn_i(m_q[REG_AW-1:0]),
    .sel_o(fwda), .load_hit_o(lh_a)
  );
  fwd_sel #(.REG_AW(REG_AW)) u_sel_b (
    .act_i(d_valid & d_use_rt), .src_i(d_rt),
    .ewreg_i(e_q[REG_AW+1]), .em2reg_i(e_q[REG_AW]), .ern_i(e_q[REG_AW-1:0]),
    .mwreg_i(m_q[REG_AW+1]), .mm2reg_i(m_q[REG_AW]), .mrn_i(m_q[REG_AW-1:0]),
    .sel_o(fwdb), .load_hit_o(lh_b)
  );
  assign stall     = lh_a | lh_b;
  assign stall_cnt = cnt_q;
  always_comb begin
    e_d   = (stall | ~d_valid) ? '0 : {d_wreg, d_m2reg, d_rn};
    cnt_d = clr_cnt ? '0 : (stall & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= e_q;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: scoreboard bench; a pipeline-history model predicts selects, stall and counter.
module tb_fwd_hazard_unit;
  localparam int AW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0, clrn = 1'b0;
  logic d_valid = 1'b0, d_use_rs = 1'b0, d_use_rt = 1'b0, d_wreg = 1'b0, d_m2reg = 1'b0, clr_cnt = 1'b0;
  logic [AW-1:0] d_rs = '0, d_rt = '0, d_rn = '0;
  logic [1:0] fwda, fwdb;
  logic stall;
  logic [CW-1:0] stall_cnt;
  always #5 clk = ~clk;
  fwd_hazard_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .clrn(clrn), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_wreg(d_wreg), .d_m2reg(d_m2reg),
    .d_rn(d_rn), .clr_cnt(clr_cnt), .fwda(fwda), .fwdb(fwdb), .stall(stall),
    .stall_cnt(stall_cnt)
  );
  typedef struct packed {
    logic valid, urs, urt, wreg, m2reg, clr;
    logic [AW-1:0] rs, rt, rn;
  } ins_t;
  typedef struct packed {
    logic [1:0] fa, fb;
    logic st;
    logic [CW-1:0] cnt;
  } exp_t;
  typedef struct {
    bit wr, ld;
    int rn;
  } slot_t;
  slot_t pipe[2];
  int    cnt_m;
  ins_t  last;
  bit    last_st;
  exp_t  q[$];
  int    n_chk = 0, n_pass = 0;
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask
  // youngest in-flight writer of src: 0 none, 1 EXE alu, 2 EXE load, 3 MEM alu, 4 MEM load
  function automatic int who(int src);
    for (int i = 0; i < 2; i++)
      if (src != 0 && pipe[i].wr && pipe[i].rn == src) return i * 2 + int'(pipe[i].ld) + 1;
    return 0;
  endfunction
  function automatic logic [1:0] sel_of(int k);
    return (k == 1) ? 2'b01 : (k == 3) ? 2'b10 : (k == 4) ? 2'b11 : 2'b00;
  endfunction
  function automatic exp_t predict(ins_t d);
    exp_t e;
    int ka, kb;
    ka = (d.valid && d.urs) ? who(int'(d.rs)) : 0;
    kb = (d.valid && d.urt) ? who(int'(d.rt)) : 0;
    e.fa = sel_of(ka);
    e.fb = sel_of(kb);
    e.st = (ka == 2) || (kb == 2);
    e.cnt = CW'(cnt_m);
    return e;
  endfunction
  task automatic model_edge();
    if (last.clr) cnt_m = 0;
    else if (last_st && cnt_m < CMAX) cnt_m++;
    pipe[1] = pipe[0];
    if (last_st || !last.valid) pipe[0] = '{0, 0, 0};
    else pipe[0] = '{last.wreg, last.m2reg, int'(last.rn)};
  endtask
  task automatic model_reset();
    pipe[0] = '{0, 0, 0};
    pipe[1] = '{0, 0, 0};
    cnt_m = 0;
    last = '0;
    last_st = 0;
  endtask
  task automatic drive(ins_t d);
    d_valid = d.valid; d_rs = d.rs; d_rt = d.rt; d_use_rs = d.urs; d_use_rt = d.urt;
    d_wreg = d.wreg; d_m2reg = d.m2reg; d_rn = d.rn; clr_cnt = d.clr;
  endtask
  task automatic issue(ins_t d);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1 drive(d);
    e = predict(d);
    q.push_back(e);
    last = d;
    last_st = e.st;
  endtask
  function automatic ins_t mk(bit v, int rs, int rt, bit urs, bit urt, bit w, bit m, int rn);
    ins_t r;
    r.valid = v; r.rs = AW'(rs); r.rt = AW'(rt); r.urs = urs; r.urt = urt;
    r.wreg = w; r.m2reg = m; r.rn = AW'(rn); r.clr = 1'b0;
    return r;
  endfunction
  function automatic ins_t rnd();
    ins_t r;
    r = mk($urandom_range(0, 9) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 3));
    r.clr = $urandom_range(0, 19) == 0;
    return r;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("fwda", int'(fwda), int'(e.fa));
      chk("fwdb", int'(fwdb), int'(e.fb));
      chk("stall", int'(stall), int'(e.st));
      chk("stall_cnt", int'(stall_cnt), int'(e.cnt));
    end
  end
  initial begin
    ins_t c, c2, d;
    model_reset();
    drive(mk(1, 3, 4, 1, 1, 1, 1, 3));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fwda", int'(fwda), 0);
    chk("rst_fwdb", int'(fwdb), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_cnt", int'(stall_cnt), 0);
    drive('0);
    @(negedge clk) clrn = 1'b1;
    issue(mk(1, 1, 2, 1, 1, 1, 0, 5));
    issue(mk(1, 0, 0, 0, 0, 1, 0, 3));
    issue(mk(1, 3, 7, 1, 1, 1, 0, 8));
    issue(mk(1, 9, 3, 1, 1, 0, 0, 0));
    c = mk(1, 4, 4, 1, 1, 1, 0, 9);
    issue(mk(1, 1, 0, 1, 0, 1, 1, 4));
    issue(c);
    issue(c);
    issue(mk(1, 0, 0, 0, 0, 1, 0, 6));
    issue(mk(1, 0, 0, 0, 0, 1, 0, 6));
    issue(mk(1, 6, 6, 1, 1, 0, 0, 0));
    issue(mk(1, 0, 0, 0, 0, 1, 0, 0));
    issue(mk(1, 0, 0, 1, 1, 1, 0, 10));
    issue(mk(1, 0, 0, 0, 0, 1, 1, 0));
    issue(mk(1, 0, 0, 1, 1, 0, 0, 0));
    issue(mk(1, 0, 0, 0, 0, 1, 0, 7));
    issue(mk(1, 0, 0, 0, 0, 1, 1, 7));
    c = mk(1, 7, 1, 1, 1, 0, 0, 0);
    issue(c);
    issue(c);
    issue(mk(1, 0, 0, 0, 0, 1, 1, 2));
    issue(mk(0, 2, 2, 1, 1, 1, 1, 2));
    c = mk(1, 1, 0, 1, 0, 1, 1, 1);
    issue(c);
    for (int i = 0; i < CMAX + 4; i++) begin
      issue(c);
      issue(c);
    end
    c2 = c;
    c2.clr = 1'b1;
    issue(c2);
    issue(c);
    issue(mk(1, 0, 0, 0, 0, 1, 1, 2));
    issue(mk(1, 2, 0, 1, 0, 0, 0, 0));
    #1 chk("pre_rst_stall", int'(stall), 1);
    clrn = 1'b0;
    #1;
    chk("async_rst_stall", int'(stall), 0);
    chk("async_rst_fwda", int'(fwda), 0);
    chk("async_rst_cnt", int'(stall_cnt), 0);
    q.delete();
    drive('0);
    model_reset();
    @(posedge clk);
    @(negedge clk) clrn = 1'b1;
    d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!last_st) d = rnd();
      issue(d);
    end
    issue('0);
    repeat (3) @(negedge clk);
    if (q.size() != 0) chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Forwarding and load-use hazard controller for the 5-stage integer pipeline.
- Tracks the destination tags of the instructions in the EXE and MEM stages internally. It then drives the 2-bit selects of the A- and B-operand forwarding muxes.
  - 00 = register file qa/qb
  - 01 = EXE ALU result r
  - 10 = EXE/MEM latched result mr
  - 11 = data-memory output mdo
- Raises a stall when a load in EXE feeds the instruction in ID, and inserts the bubble itself.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- REG_AW, 5, register-number width (32 registers; register 0 hardwired zero).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- d_valid  in  1  ID-stage instruction is real; 0 means treat as a bubble.
- d_rs  in  REG_AW  ID source register A.
- d_rt  in  REG_AW  ID source register B.
- d_use_rs  in  1  ID instruction reads rs.
- d_use_rt  in  1  ID instruction reads rt.
- d_wreg  in  1  ID instruction writes the register file.
- d_m2reg  in  1  ID instruction is a load (result comes from memory).
- d_rn  in  REG_AW  ID destination register.
- clr_cnt  in  1  synchronous clear of stall_cnt.
- fwda  out  2  A-operand forward select.
- fwdb  out  2  B-operand forward select.
- stall  out  1  hold PC and IF/ID this cycle (wpcir = ~stall upstream).
- stall_cnt  out  CNT_W  cycles spent stalled, saturating.

Behaviour:
- State: the E tag {ewreg, em2reg, ern} and the M tag {mwreg, mm2reg, mrn}, all registered on clk.
- Reset (clrn=0, asynchronous):
  - E and M tags cleared to 0; stall_cnt = 0.
  - Outputs: fwda = fwdb = 00, stall = 0.
  - Reset asserted mid-stall drops stall immediately. Upstream is responsible for refetch.
- Each clock edge:
  - M tag <= E tag.
  - E tag <= bubble {0,0,0} if stall=1 or d_valid=0. Otherwise E tag <= {d_wreg, d_m2reg, d_rn}.
- Match rule, per operand with x = rs or rt:
  - E-hit = ewreg & (ern==d_x) & (ern!=0).
  - M-hit = mwreg & (mrn==d_x) & (mrn!=0).
  - Only evaluated when d_valid & d_use_x.
- Select priority, youngest wins:
  - E-hit and !em2reg -> 01.
  - Else M-hit and mm2reg -> 11.
  - Else M-hit -> 10.
  - Else -> 00.
- Load-use: stall = d_valid & ((d_use_rs & E-hit_rs & em2reg) | (d_use_rt & E-hit_rt & em2reg)).
  - During stall, the stalled operand's select is forced to 00.
  - Next cycle, the load sits in M and the select resolves to 11.
  - The stall lasts exactly 1 cycle per load-use pair.
- fwda, fwdb and stall are combinational from registered tags and ID inputs: 0-cycle latency, no registered outputs.
- Register 0 is never forwarded and never causes a stall, even if wreg=1.
- E and M both match the same source: E wins. If E is a load, stall.
- Both operands depend on the same EXE load: a single stall, and both selects are 11 next cycle.
- stall_cnt:
  - +1 on each clock edge where stall=1.
  - Saturates at all-ones.
  - clr_cnt has priority over the increment.
- d_valid=0: stall=0 and selects are 00, regardless of tags.

Decomposition:
- Shared package:
  - FWD_QA=2'b00, FWD_R=2'b01, FWD_MR=2'b10, FWD_MDO=2'b11.
  - REG_AW default.
  - Pipe-tag struct/constant layout {wreg, m2reg, rn} and the BUBBLE tag constant.
- Sub-module fwd_sel: combinational per-operand match and priority encoder, producing select plus load-hit. It is instantiated twice (rs, rt). Tag registers and the counter stay in the top.

Test Plan:
- Reset: hold clrn=0 with arbitrary ID inputs -> fwda=fwdb=00, stall=0, stall_cnt=0. Release, then issue add r5 with no producers -> selects 00.
- ALU chain: add r3 (wreg=1, rn=3), next cycle sub reading rs=3 -> fwda=01. The cycle after, an instruction reading rt=3 -> fwdb=10.
- Load-use: lw r4, then add with rs=4 and rt=4 -> stall=1 with fwda=fwdb=00 for 1 cycle. Next cycle (ID held) -> stall=0, fwda=fwdb=11, stall_cnt=1.
- Priority: add r6 followed by or r6, then an instruction reading rs=6 -> fwda=01 (E wins over M).
- Zero register: producer with wreg=1, rn=0, followed by a consumer with rs=0 -> fwda=00, stall=0. The same holds for a load with rn=0 -> no stall.
- Counter: force 2^CNT_W+3 load-use stalls -> stall_cnt stays at 0xFFFF. Pulse clr_cnt during a stall cycle -> stall_cnt=0.
